weight_loader: RTL

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader.sv | 92 +++++++++
 1 files changed

// File: rtl/weight_loader.sv
// Weight table loader: streams DEPTH words into a local RAM, tracks count and XOR checksum,
// and serves registered read-first lookups to the layer engine.
module weight_loader #(
  parameter int DW    = 32,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic [AW-1:0] rom_addr,
  output logic [DW-1:0] rom_data,
  output logic          load_done,
  output logic [AW:0]   load_count,
  output logic [DW-1:0] checksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t        state_q;
  logic          wr_ready_q;
  logic          load_done_q;
  logic [AW:0]   count_q;
  logic [DW-1:0] csum_q;
  logic [DW-1:0] rom_data_q;
  logic [DW-1:0] mem [DEPTH];
  logic          accept;

  // wr_ready_q is high exactly while in LOAD, so acceptance needs no state decode here
  assign accept = wr_valid & wr_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      count_q     <= '0;
      csum_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (load_start) begin
            state_q     <= S_LOAD;
            wr_ready_q  <= 1'b1;
            load_done_q <= 1'b0;
            count_q     <= '0;
            csum_q      <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            count_q <= count_q + ONE;
            csum_q  <= csum_q ^ wr_data;
            if (count_q == LAST) begin
              state_q     <= S_DONE;
              wr_ready_q  <= 1'b0;
              load_done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          wr_ready_q  <= 1'b0;
          load_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Array is deliberately not reset; contents survive reset and reloads
  always_ff @(posedge clk) begin
    if (accept) mem[count_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rom_data_q <= '0;
    else     rom_data_q <= mem[rom_addr];
  end

  assign wr_ready   = wr_ready_q;
  assign load_done  = load_done_q;
  assign load_count = count_q;
  assign checksum   = csum_q;
  assign rom_data   = rom_data_q;

endmodule
